// File: rtl/ring_decoder_monitor_module_pkg.sv
// Shared types and helpers for the ring decoder monitor.
// Rotation helpers work on a RING_MAX_W-bit container and only the low w bits matter.
package ring_pkg;

  localparam int unsigned RING_WIDTH_DEFAULT = 4;
  localparam int unsigned RING_MAX_W         = 64;

  // 2'd3 is never produced; the FSM decodes it as SYNC.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } ring_state_t;

  function automatic logic [RING_MAX_W-1:0] ring_mask(input int unsigned w);
    logic [RING_MAX_W-1:0] m;
    m = '1;
    return ~(m << w);
  endfunction

  // Rotate the low w bits left by one (bit i -> bit i+1, top bit -> bit 0).
  function automatic logic [RING_MAX_W-1:0] rotl(input logic [RING_MAX_W-1:0] vec,
                                                  input int unsigned w);
    logic [RING_MAX_W-1:0] v;
    v = vec & ring_mask(w);
    return ((v << 1) | (v >> (w - 1))) & ring_mask(w);
  endfunction

  // Rotate the low w bits right by one (bit i -> bit i-1, bit 0 -> top bit).
  function automatic logic [RING_MAX_W-1:0] rotr(input logic [RING_MAX_W-1:0] vec,
                                                  input int unsigned w);
    logic [RING_MAX_W-1:0] v;
    v = vec & ring_mask(w);
    return ((v >> 1) | (v << (w - 1))) & ring_mask(w);
  endfunction

endpackage

// File: rtl/ring_decoder_monitor_module_if.sv
// Sample/status bundle for the ring decoder monitor.
// The dir signal exists only when RING_MON_BIDIR_EN is defined.
interface ring_decoder_monitor_module_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAP_W = 8,
  localparam int unsigned IW   = $clog2(WIDTH)
);
  logic             en;
  logic [WIDTH-1:0] ring_in;
  logic             clr_err;
  logic [IW-1:0]    index;
  logic             index_valid;
  logic [LAP_W-1:0] lap_count;
  logic             lap_pulse;
  logic             code_err;
  logic             step_err;
  logic             err_sticky;
  logic [1:0]       state;
`ifdef RING_MON_BIDIR_EN
  logic             dir;
`endif

  modport master (
    output en, ring_in, clr_err,
    input  index, index_valid, lap_count, lap_pulse, code_err, step_err, err_sticky, state
`ifdef RING_MON_BIDIR_EN
    , input dir
`endif
  );

  modport slave (
    input  en, ring_in, clr_err,
    output index, index_valid, lap_count, lap_pulse, code_err, step_err, err_sticky, state
`ifdef RING_MON_BIDIR_EN
    , output dir
`endif
  );
endinterface

// File: rtl/ring_decoder_monitor_module_onehot_to_bin.sv
// One-hot to binary decoder: legal when exactly one bit is set; idx is 0 otherwise.
module onehot_to_bin_module #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_in,
  output logic             legal,
  output logic [IW-1:0]    idx
);
  int unsigned       cnt;
  logic [IW-1:0]     acc;

  // Popcount and OR-reduce the positions of set bits.
  always_comb begin
    cnt = 0;
    acc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        cnt = cnt + 1;
        acc = acc | IW'(i);
      end
    end
    legal = (cnt == 1);
    idx   = legal ? acc : '0;
  end
endmodule

// File: rtl/ring_decoder_monitor_module.sv
// Ring decoder monitor: decodes one-hot ring samples, checks rotation steps, counts laps.
// Define RING_MON_BIDIR_EN to accept reverse rotation with a latched direction (dir output).
module ring_decoder_monitor_module
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = RING_WIDTH_DEFAULT,
  parameter int unsigned LAP_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  ring_decoder_monitor_module_if.slave bus
);
  localparam int unsigned IW = $clog2(WIDTH);

  ring_state_t      state_q;
  logic [WIDTH-1:0] prev_q;
  logic [IW-1:0]    index_q;
  logic             index_valid_q;
  logic [LAP_W-1:0] lap_count_q;
  logic             lap_pulse_q;
  logic             code_err_q;
  logic             step_err_q;
  logic             err_sticky_q;

  logic             legal;
  logic [IW-1:0]    idx_d;
  logic [WIDTH-1:0] fwd;
  logic             is_hold;
  logic             is_fwd;
  logic             is_rev;
  logic             is_lap;

  onehot_to_bin_module #(.WIDTH(WIDTH)) u_dec (
    .ring_in (bus.ring_in),
    .legal   (legal),
    .idx     (idx_d)
  );

  assign fwd = WIDTH'(rotl(RING_MAX_W'(prev_q), WIDTH));

`ifdef RING_MON_BIDIR_EN
  logic [WIDTH-1:0] rev;
  logic             dir_q;
  logic             dir_lock_q;

  assign rev = WIDTH'(rotr(RING_MAX_W'(prev_q), WIDTH));

  // Step classification; once direction is latched the opposite rotation is illegal.
  always_comb begin
    is_hold = (bus.ring_in == prev_q);
    is_fwd  = (bus.ring_in == fwd) && !(dir_lock_q && dir_q);
    is_rev  = (bus.ring_in == rev) && !(dir_lock_q && !dir_q) && !is_fwd;
    is_lap  = (is_fwd && prev_q[WIDTH-1]) || (is_rev && prev_q[0]);
  end

  assign bus.dir = dir_q;
`else
  // Step classification, forward rotation only.
  always_comb begin
    is_hold = (bus.ring_in == prev_q);
    is_fwd  = (bus.ring_in == fwd);
    is_rev  = 1'b0;
    is_lap  = is_fwd && prev_q[WIDTH-1];
  end
`endif

  // Monitor FSM with registered status, pulses and lap counter; clr_err outranks en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SYNC;
      prev_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      lap_count_q   <= '0;
      lap_pulse_q   <= 1'b0;
      code_err_q    <= 1'b0;
      step_err_q    <= 1'b0;
      err_sticky_q  <= 1'b0;
`ifdef RING_MON_BIDIR_EN
      dir_q         <= 1'b0;
      dir_lock_q    <= 1'b0;
`endif
    end else begin
      lap_pulse_q <= 1'b0;
      code_err_q  <= 1'b0;
      step_err_q  <= 1'b0;
      if (bus.clr_err) begin
        err_sticky_q  <= 1'b0;
        state_q       <= SYNC;
        index_valid_q <= 1'b0;
`ifdef RING_MON_BIDIR_EN
        dir_q         <= 1'b0;
        dir_lock_q    <= 1'b0;
`endif
      end else if (bus.en) begin
        case (state_q)
          TRACK: begin
            if (!legal) begin
              code_err_q    <= 1'b1;
              err_sticky_q  <= 1'b1;
              state_q       <= FAULT;
              index_valid_q <= 1'b0;
            end else if (is_hold) begin
              // hold: prev and index already match the sample
            end else if (is_fwd || is_rev) begin
              prev_q  <= bus.ring_in;
              index_q <= idx_d;
              if (is_lap) begin
                lap_count_q <= lap_count_q + 1'b1;
                lap_pulse_q <= 1'b1;
              end
`ifdef RING_MON_BIDIR_EN
              if (!dir_lock_q) begin
                dir_lock_q <= 1'b1;
                dir_q      <= is_rev;
              end
`endif
            end else begin
              step_err_q    <= 1'b1;
              err_sticky_q  <= 1'b1;
              state_q       <= FAULT;
              index_valid_q <= 1'b0;
            end
          end
          FAULT: begin
            // samples ignored until clr_err
          end
          default: begin
            if (legal) begin
              prev_q        <= bus.ring_in;
              index_q       <= idx_d;
              state_q       <= TRACK;
              index_valid_q <= 1'b1;
`ifdef RING_MON_BIDIR_EN
              dir_q         <= 1'b0;
              dir_lock_q    <= 1'b0;
`endif
            end else begin
              code_err_q   <= 1'b1;
              err_sticky_q <= 1'b1;
              state_q      <= SYNC;
            end
          end
        endcase
      end
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.lap_count   = lap_count_q;
  assign bus.lap_pulse   = lap_pulse_q;
  assign bus.code_err    = code_err_q;
  assign bus.step_err    = step_err_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_ring_decoder_monitor_module.sv
// Bench for ring_decoder_monitor_module (WIDTH=4, LAP_W=8): directed scenarios plus
// randomized samples checked against an integer-position reference model.
module tb_ring_decoder_monitor_module;
  localparam int W    = 4;
  localparam int LAPS = 256;
`ifdef RING_MON_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ring_decoder_monitor_module_if #(.WIDTH(W), .LAP_W(8)) bus ();

  ring_decoder_monitor_module #(.WIDTH(W), .LAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: position as an integer, modes 0=sync 1=track 2=fault
  int m_state, m_idx, m_valid, m_lap, m_lp, m_ce, m_se, m_sticky, m_dir, m_locked;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int popcount(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int hot_pos(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_valid = 0; m_lap = 0; m_lp = 0;
    m_ce = 0; m_se = 0; m_sticky = 0; m_dir = 0; m_locked = 0;
  endtask

  task automatic model_fault(input bit is_code);
    if (is_code) m_ce = 1; else m_se = 1;
    m_sticky = 1; m_state = 2; m_valid = 0;
  endtask

  task automatic model_lap();
    m_lap = (m_lap + 1) % LAPS;
    m_lp  = 1;
  endtask

  task automatic model_step(input logic e, input logic [W-1:0] r, input logic c);
    int pc, h, nxt, prv;
    m_lp = 0; m_ce = 0; m_se = 0;
    pc = popcount(r); h = hot_pos(r);
    nxt = (m_idx + 1) % W; prv = (m_idx + W - 1) % W;
    if (c) begin
      m_sticky = 0; m_state = 0; m_valid = 0; m_dir = 0; m_locked = 0;
    end else if (e) begin
      if (m_state == 0) begin
        if (pc == 1) begin
          m_idx = h; m_state = 1; m_valid = 1; m_dir = 0; m_locked = 0;
        end else begin
          m_ce = 1; m_sticky = 1;
        end
      end else if (m_state == 1) begin
        if (pc != 1) model_fault(1'b1);
        else if (h == m_idx) begin end
        else if (h == nxt && !(m_locked == 1 && m_dir == 1)) begin
          if (m_idx == W - 1) model_lap();
          m_idx = h;
          if (BIDIR && m_locked == 0) begin m_locked = 1; m_dir = 0; end
        end else if (BIDIR && h == prv && !(m_locked == 1 && m_dir == 0)) begin
          if (m_idx == 0) model_lap();
          m_idx = h; m_locked = 1; m_dir = 1;
        end else model_fault(1'b0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".index"},       64'(bus.index),       64'(m_idx));
    check({tag, ".index_valid"}, 64'(bus.index_valid), 64'(m_valid));
    check({tag, ".lap_count"},   64'(bus.lap_count),   64'(m_lap));
    check({tag, ".lap_pulse"},   64'(bus.lap_pulse),   64'(m_lp));
    check({tag, ".code_err"},    64'(bus.code_err),    64'(m_ce));
    check({tag, ".step_err"},    64'(bus.step_err),    64'(m_se));
    check({tag, ".err_sticky"},  64'(bus.err_sticky),  64'(m_sticky));
    check({tag, ".state"},       64'(bus.state),       64'(m_state));
`ifdef RING_MON_BIDIR_EN
    check({tag, ".dir"},         64'(bus.dir),         64'(m_dir));
`endif
  endtask

  task automatic step(input string tag, input logic e, input logic [W-1:0] r, input logic c);
    bus.en = e; bus.ring_in = r; bus.clr_err = c;
    @(posedge clk);
    model_step(e, r, c);
    #1;
    check_all(tag);
  endtask

  // asynchronous reset placed between edges; outputs must clear before the next edge
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] seq1 [5];
    logic [W-1:0] pat;
    int r;
    bus.en = 1'b0; bus.ring_in = '0; bus.clr_err = 1'b0;
    model_reset();
    #3 check_all("rst0");
    #13 check_all("rst1");
    #1 rst = 1'b1;

    // 1: one full forward lap from sync
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    foreach (seq1[i]) step("t1", 1'b1, seq1[i], 1'b0);
    check("t1.lap_final", 64'(bus.lap_count), 64'd1);
    check("t1.idx_final", 64'(bus.index), 64'd0);

    // 2: multi-hot in TRACK
    step("t2a", 1'b1, 4'b0010, 1'b0);
    step("t2b", 1'b1, 4'b0011, 1'b0);
    check("t2.state_fault", 64'(bus.state), 64'd2);
    check("t2.index_hold", 64'(bus.index), 64'd1);
    step("t2c", 1'b0, 4'b0000, 1'b1);
    check("t2.state_sync", 64'(bus.state), 64'd0);

    // 3: skip step, then samples ignored in FAULT
    step("t3a", 1'b1, 4'b0001, 1'b0);
    step("t3b", 1'b1, 4'b0100, 1'b0);
    check("t3.step_err", 64'(bus.step_err), 64'd1);
    step("t3c", 1'b1, 4'b1000, 1'b0);
    step("t3d", 1'b1, 4'b0001, 1'b0);
    check("t3.still_fault", 64'(bus.state), 64'd2);
    step("t3e", 1'b1, 4'b0010, 1'b1);

    // 4: hold then idle
    step("t4a", 1'b1, 4'b0100, 1'b0);
    repeat (3) step("t4b", 1'b1, 4'b0100, 1'b0);
    repeat (2) step("t4c", 1'b0, 4'b0001, 1'b0);
    check("t4.index", 64'(bus.index), 64'd2);

    // 5: 256 laps wrap the counter, then reset mid-lap
    do_reset("t5rst");
    step("t5s", 1'b1, 4'b0001, 1'b0);
    for (int lap = 0; lap < LAPS; lap++) begin
      step("t5", 1'b1, 4'b0010, 1'b0);
      step("t5", 1'b1, 4'b0100, 1'b0);
      step("t5", 1'b1, 4'b1000, 1'b0);
      step("t5", 1'b1, 4'b0001, 1'b0);
    end
    check("t5.wrap_count", 64'(bus.lap_count), 64'd0);
    check("t5.wrap_pulse", 64'(bus.lap_pulse), 64'd1);
    step("t5m", 1'b1, 4'b0010, 1'b0);
    do_reset("t5mid");
    step("t5r", 1'b1, 4'b0100, 1'b0);
    check("t5.resync", 64'(bus.index_valid), 64'd1);

`ifdef RING_MON_BIDIR_EN
    // 6: reverse lap and opposite-direction step
    do_reset("t6rst");
    seq1 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    foreach (seq1[i]) step("t6", 1'b1, seq1[i], 1'b0);
    check("t6.dir", 64'(bus.dir), 64'd1);
    check("t6.lap", 64'(bus.lap_count), 64'd1);
    step("t6b", 1'b1, 4'b0001, 1'b0);
    check("t6.step_err", 64'(bus.step_err), 64'd1);
`endif

    // randomized traffic
    step("rnd0", 1'b0, 4'b0000, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       step("rnd", 1'b0, W'($urandom_range(0, 15)), 1'b0);
      else if (r < 12) step("rnd", ($urandom_range(0, 1) == 1), W'($urandom_range(0, 15)), 1'b1);
      else if (r < 18) step("rnd", 1'b1, W'($urandom_range(0, 15)), 1'b0);
      else begin
        if (r < 26)      pat = W'(1 << m_idx);
        else if (r < 32) pat = W'(1 << ((m_idx + W - 1) % W));
        else             pat = W'(1 << ((m_idx + 1) % W));
        step("rnd", 1'b1, pat, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
